// File: rtl/fir_xifu_pkg.sv
// rtl/fir_xifu_pkg.sv - shared types for the FIR XIFU write-back buffer
package fir_xifu_pkg;

  localparam int unsigned FIR_XLEN   = 32;
  localparam int unsigned FIR_NUM_ID = 4;
  localparam int unsigned FIR_ID_W   = $clog2(FIR_NUM_ID);

  typedef enum logic [1:0] {
    INSTR_INVALID = 2'd0,
    XFIRLW        = 2'd1,
    XFIRSW        = 2'd2,
    XFIRDOTP      = 2'd3
  } instr_t;

  typedef struct packed {
    logic [FIR_ID_W-1:0] id;
    instr_t              instr;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [FIR_XLEN-1:0] addr_next;
    logic [FIR_XLEN-1:0] result;
    logic [FIR_XLEN-1:0] rdata;
    logic                mem_done;
  } wb_entry_t;

  typedef struct packed {
    logic [FIR_NUM_ID-1:0] clear;
    logic                  kill;
  } wb_buf_ctrl_t;

endpackage

// File: rtl/fir_xifu_wb_queue.sv
// rtl/fir_xifu_wb_queue.sv - in-order circular buffer of write-back entries
// with ID-associative capture of out-of-order memory results.
module fir_xifu_wb_queue
  import fir_xifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ID_W  = FIR_ID_W,
  parameter int unsigned XLEN  = FIR_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  wb_entry_t       push_entry_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic            mem_valid_i,
  input  logic [ID_W-1:0] mem_id_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output wb_entry_t       head_o,
  output wb_entry_t       entries_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [DEPTH-1:0] valid_q;
  wb_entry_t        entry_q [DEPTH];
  wb_entry_t        push_cap;

  // A result strobe racing the push of its own instruction is folded in here.
  always_comb begin
    push_cap = push_entry_i;
    if (mem_valid_i && (mem_id_i == push_entry_i.id)) begin
      push_cap.rdata    = mem_rdata_i;
      push_cap.mem_done = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_valid_i && valid_q[i] && (entry_q[i].id == mem_id_i)) begin
          entry_q[i].rdata    <= mem_rdata_i;
          entry_q[i].mem_done <= 1'b1;
        end
      end
      if (pop_i) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_ONE;
      end
      // Push after pop so a full queue can refill the slot it just freed.
      if (push_i) begin
        entry_q[tail_q] <= push_cap;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_ONE;
      end
    end
  end

  assign head_o    = entry_q[head_q];
  assign entries_o = entry_q;
  assign valid_o   = valid_q;
  assign full_o    = valid_q[tail_q];
  assign empty_o   = ~valid_q[head_q];

endmodule

// File: rtl/fir_xifu_wb_buf.sv
// rtl/fir_xifu_wb_buf.sv - multi-entry write-back stage: retires queued
// instructions in order once committed and complete, and handles kill.
module fir_xifu_wb_buf
  import fir_xifu_pkg::*;
#(
  parameter int unsigned XLEN   = FIR_XLEN,
  parameter int unsigned NUM_ID = FIR_NUM_ID,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned ID_W  = $clog2(NUM_ID)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ID_W-1:0]   ex_id_i,
  input  instr_t            ex_instr_i,
  input  logic [4:0]        ex_rd_i,
  input  logic [4:0]        ex_rs1_i,
  input  logic [XLEN-1:0]   ex_addr_next_i,
  input  logic [XLEN-1:0]   ex_result_i,
  input  logic              mem_result_valid_i,
  input  logic [ID_W-1:0]   mem_result_id_i,
  input  logic [XLEN-1:0]   mem_result_rdata_i,
  input  logic [NUM_ID-1:0] issue_i,
  input  logic [NUM_ID-1:0] commit_i,
  input  logic [NUM_ID-1:0] kill_i,
  output logic [NUM_ID-1:0] clear_o,
  output logic              rf_write_o,
  output logic [4:0]        rf_rd_o,
  output logic [XLEN-1:0]   rf_result_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic [ID_W-1:0]   result_id_o,
  output logic [4:0]        result_rd_o,
  output logic [XLEN-1:0]   result_data_o,
  output logic              result_we_o,
  output logic              fwd_we_o,
  output logic [4:0]        fwd_rd_o,
  output logic [XLEN-1:0]   fwd_result_o,
  output logic              kill_o
);

  wb_entry_t        head;
  wb_entry_t        push_entry;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             full;
  logic             empty;
  logic             push;
  logic             retire;
  logic             kill_hit;
  logic             head_ready;
  wb_buf_ctrl_t     ctrl;

  // Stalling on an uncommitted head needs only commit_i; issue_i is informational.
  logic unused_issue;
  assign unused_issue = ^issue_i;

  always_comb begin
    push_entry           = '0;
    push_entry.id        = ex_id_i;
    push_entry.instr     = ex_instr_i;
    push_entry.rd        = ex_rd_i;
    push_entry.rs1       = ex_rs1_i;
    push_entry.addr_next = ex_addr_next_i;
    push_entry.result    = ex_result_i;
  end

  fir_xifu_wb_queue #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W),
    .XLEN  (XLEN)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (retire),
    .flush_i      (kill_hit),
    .mem_valid_i  (mem_result_valid_i),
    .mem_id_i     (mem_result_id_i),
    .mem_rdata_i  (mem_result_rdata_i),
    .head_o       (head),
    .entries_o    (entries),
    .valid_o      (valid),
    .full_o       (full),
    .empty_o      (empty)
  );

  // Reset suppresses kill and retire so a mid-operation reset emits no clears.
  always_comb begin
    kill_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && kill_i[entries[i].id]) begin
        kill_hit = 1'b1;
      end
    end
    kill_hit = kill_hit & ~rst_i;
  end

  always_comb begin
    head_ready = 1'b0;
    case (head.instr)
      XFIRLW, XFIRSW: head_ready = commit_i[head.id] & head.mem_done;
      XFIRDOTP:       head_ready = commit_i[head.id];
      default:        head_ready = 1'b0;
    endcase
  end

  assign result_valid_o = ~empty & head_ready & ~kill_hit & ~rst_i;
  assign retire         = result_valid_o & result_ready_i;
  assign ex_ready_o     = ~full | retire;
  assign push           = ex_valid_i & ex_ready_o & (ex_instr_i != INSTR_INVALID) & ~kill_hit;

  always_comb begin
    rf_write_o    = 1'b0;
    rf_rd_o       = '0;
    rf_result_o   = '0;
    result_id_o   = '0;
    result_rd_o   = '0;
    result_data_o = '0;
    result_we_o   = 1'b0;
    if (result_valid_o) begin
      result_id_o = head.id;
      if (head.instr == XFIRLW || head.instr == XFIRSW) begin
        result_we_o   = 1'b1;
        result_rd_o   = head.rs1;
        result_data_o = head.addr_next;
      end
    end
    if (retire) begin
      case (head.instr)
        XFIRLW: begin
          rf_write_o  = 1'b1;
          rf_rd_o     = head.rd;
          rf_result_o = head.rdata;
        end
        XFIRDOTP: begin
          rf_write_o  = 1'b1;
          rf_rd_o     = head.rd;
          rf_result_o = head.result;
        end
        default: ;
      endcase
    end
  end

  assign fwd_we_o     = result_we_o;
  assign fwd_rd_o     = result_rd_o;
  assign fwd_result_o = result_data_o;

  always_comb begin
    ctrl = '0;
    if (kill_hit) begin
      ctrl.kill = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i]) begin
          ctrl.clear[entries[i].id] = 1'b1;
        end
      end
    end else if (retire) begin
      ctrl.clear[head.id] = 1'b1;
    end
  end

  assign clear_o = ctrl.clear;
  assign kill_o  = ctrl.kill;

endmodule

// File: tb/tb_fir_xifu_wb_buf.sv
// tb/tb_fir_xifu_wb_buf.sv - directed bench for fir_xifu_wb_buf with an
// in-order retire scoreboard.
module tb_fir_xifu_wb_buf;
  import fir_xifu_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_id;
  instr_t      ex_instr;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_rs1;
  logic [31:0] ex_addr_next;
  logic [31:0] ex_result;
  logic        mem_valid;
  logic [1:0]  mem_id;
  logic [31:0] mem_rdata;
  logic [3:0]  issue;
  logic [3:0]  commit;
  logic [3:0]  kill;
  logic [3:0]  clear;
  logic        rf_write;
  logic [4:0]  rf_rd;
  logic [31:0] rf_result;
  logic        result_valid;
  logic        result_ready;
  logic [1:0]  result_id;
  logic [4:0]  result_rd;
  logic [31:0] result_data;
  logic        result_we;
  logic        fwd_we;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_result;
  logic        kill_out;

  typedef struct {
    logic [1:0]  id;
    instr_t      instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] addr;
    logic [31:0] res;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  fir_xifu_wb_buf dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .ex_valid_i         (ex_valid),
    .ex_ready_o         (ex_ready),
    .ex_id_i            (ex_id),
    .ex_instr_i         (ex_instr),
    .ex_rd_i            (ex_rd),
    .ex_rs1_i           (ex_rs1),
    .ex_addr_next_i     (ex_addr_next),
    .ex_result_i        (ex_result),
    .mem_result_valid_i (mem_valid),
    .mem_result_id_i    (mem_id),
    .mem_result_rdata_i (mem_rdata),
    .issue_i            (issue),
    .commit_i           (commit),
    .kill_i             (kill),
    .clear_o            (clear),
    .rf_write_o         (rf_write),
    .rf_rd_o            (rf_rd),
    .rf_result_o        (rf_result),
    .result_valid_o     (result_valid),
    .result_ready_i     (result_ready),
    .result_id_o        (result_id),
    .result_rd_o        (result_rd),
    .result_data_o      (result_data),
    .result_we_o        (result_we),
    .fwd_we_o           (fwd_we),
    .fwd_rd_o           (fwd_rd),
    .fwd_result_o       (fwd_result),
    .kill_o             (kill_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input instr_t ins, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [31:0] addr, input logic [31:0] res,
                      input logic exp_ready);
    exp_t e;
    ex_valid = 1'b1; ex_id = id; ex_instr = ins; ex_rd = rd; ex_rs1 = rs1;
    ex_addr_next = addr; ex_result = res;
    #1;
    chk("ex_ready on push", ex_ready, exp_ready);
    if (exp_ready && ins != INSTR_INVALID) begin
      e.id = id; e.instr = ins; e.rd = rd; e.rs1 = rs1; e.addr = addr; e.res = res; e.rdata = '0;
      sb.push_back(e);
    end
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic mem(input logic [1:0] id, input logic [31:0] d);
    mem_valid = 1'b1; mem_id = id; mem_rdata = d;
    foreach (sb[i]) if (sb[i].id == id) sb[i].rdata = d;
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    logic we_exp;
    logic wr_exp;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: observed unexpected retire id %0h expected no retire", tag, result_id);
      return;
    end
    e = sb.pop_front();
    we_exp = (e.instr != XFIRDOTP);
    wr_exp = (e.instr != XFIRSW);
    chk({tag, " result_id"}, result_id, e.id);
    chk({tag, " result_we"}, result_we, we_exp);
    chk({tag, " fwd_we"}, fwd_we, we_exp);
    if (we_exp) begin
      chk({tag, " result_rd"}, result_rd, e.rs1);
      chk({tag, " result_data"}, result_data, e.addr);
      chk({tag, " fwd_result"}, fwd_result, e.addr);
    end
    chk({tag, " rf_write"}, rf_write, wr_exp);
    if (wr_exp) begin
      chk({tag, " rf_rd"}, rf_rd, e.rd);
      chk({tag, " rf_result"}, rf_result, (e.instr == XFIRLW) ? e.rdata : e.res);
    end
    chk({tag, " clear"}, clear, 64'd1 << e.id);
  endtask

  task automatic retire_check(input string tag, input int max_wait);
    int n = 0;
    result_ready = 1'b1;
    #1;
    while (!result_valid && n < max_wait) begin
      tick();
      n++;
    end
    chk({tag, " valid"}, result_valid, 1'b1);
    if (result_valid) compare_head(tag);
    tick();
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_id = '0; ex_instr = INSTR_INVALID; ex_rd = '0;
    ex_rs1 = '0; ex_addr_next = '0; ex_result = '0; mem_valid = 1'b0; mem_id = '0;
    mem_rdata = '0; issue = '0; commit = '0; kill = '0; result_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset ex_ready", ex_ready, 1'b1);
    chk("reset result_valid", result_valid, 1'b0);
    chk("reset kill", kill_out, 1'b0);
    chk("reset clear", clear, 4'b0000);
    chk("reset rf_write", rf_write, 1'b0);
    chk("reset result_data", result_data, 32'd0);
    chk("reset fwd_we", fwd_we, 1'b0);

    // Load with commit then memory data.
    push(2'd1, XFIRLW, 5'd3, 5'd5, 32'h0000_1004, 32'd0, 1'b1);
    issue[1] = 1'b1; commit[1] = 1'b1;
    #1;
    chk("t1 wait for data", result_valid, 1'b0);
    chk("t1 no clear while waiting", clear, 4'b0000);
    mem(2'd1, 32'hDEAD_BEEF);
    retire_check("t1 lw", 0);
    issue = '0; commit = '0;

    // Memory results out of order.
    push(2'd0, XFIRLW, 5'd10, 5'd11, 32'h0000_2000, 32'd0, 1'b1);
    push(2'd2, XFIRLW, 5'd12, 5'd13, 32'h0000_3000, 32'd0, 1'b1);
    issue = 4'b0101; commit = 4'b0101;
    mem(2'd2, 32'h2222_2222);
    chk("t2 head blocked", result_valid, 1'b0);
    mem(2'd0, 32'h1111_1111);
    retire_check("t2 id0", 0);
    retire_check("t2 id2", 0);
    issue = '0; commit = '0;

    // Dot product held by backpressure.
    push(2'd3, XFIRDOTP, 5'd7, 5'd0, 32'd0, 32'h0000_1234, 1'b1);
    issue[3] = 1'b1; commit[3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3 hold valid", result_valid, 1'b1);
      chk("t3 hold id", result_id, 2'd3);
      chk("t3 hold we", result_we, 1'b0);
      chk("t3 hold rf_write", rf_write, 1'b0);
      chk("t3 hold clear", clear, 4'b0000);
      tick();
    end
    retire_check("t3 dotp", 0);
    issue = '0; commit = '0;

    // Full queue with retire and push in the same cycle.
    push(2'd0, XFIRLW, 5'd4, 5'd6, 32'h0000_4000, 32'd0, 1'b1);
    push(2'd1, XFIRSW, 5'd0, 5'd8, 32'h0000_5000, 32'd0, 1'b1);
    chk("t4 full", ex_ready, 1'b0);
    issue = 4'b0011; commit = 4'b0001;
    mem(2'd0, 32'h0000_AAAA);
    mem(2'd1, 32'h0000_BBBB);
    result_ready = 1'b1;
    #1;
    chk("t4 retire valid", result_valid, 1'b1);
    compare_head("t4 lw");
    push(2'd2, XFIRDOTP, 5'd9, 5'd0, 32'd0, 32'h0000_9999, 1'b1);
    result_ready = 1'b0;
    #1;
    chk("t4 still full", ex_ready, 1'b0);
    issue = 4'b0111; commit = 4'b0111;
    retire_check("t4 sw", 0);
    retire_check("t4 dotp", 0);
    issue = '0; commit = '0;

    // Kill with two entries queued.
    push(2'd1, XFIRLW, 5'd2, 5'd3, 32'h0000_6000, 32'd0, 1'b1);
    push(2'd2, XFIRDOTP, 5'd4, 5'd0, 32'd0, 32'h0000_0077, 1'b1);
    issue = 4'b0110; commit = 4'b0100;
    kill[1] = 1'b1; result_ready = 1'b1;
    #1;
    chk("t5 kill", kill_out, 1'b1);
    chk("t5 clear", clear, 4'b0110);
    chk("t5 no retire", result_valid, 1'b0);
    tick();
    kill = '0;
    #1;
    chk("t5 kill one cycle", kill_out, 1'b0);
    chk("t5 clear after", clear, 4'b0000);
    chk("t5 flushed", result_valid, 1'b0);
    chk("t5 ex_ready", ex_ready, 1'b1);
    sb.delete();
    result_ready = 1'b0; issue = '0; commit = '0;

    // Kill drops a push in the same cycle.
    push(2'd1, XFIRLW, 5'd2, 5'd3, 32'h0000_6100, 32'd0, 1'b1);
    kill[1] = 1'b1; issue = 4'b1010; commit = 4'b1000;
    ex_valid = 1'b1; ex_id = 2'd3; ex_instr = XFIRDOTP; ex_rd = 5'd1; ex_result = 32'h55;
    #1;
    chk("t5b kill", kill_out, 1'b1);
    chk("t5b clear", clear, 4'b0010);
    tick();
    kill = '0; ex_valid = 1'b0;
    #1;
    chk("t5b push dropped", result_valid, 1'b0);
    sb.delete();
    issue = '0; commit = '0;

    // Reset mid-operation.
    push(2'd0, XFIRLW, 5'd1, 5'd2, 32'h0000_7000, 32'd0, 1'b1);
    push(2'd1, XFIRLW, 5'd3, 5'd4, 32'h0000_8000, 32'd0, 1'b1);
    issue = 4'b0011; commit = 4'b0001;
    rst = 1'b1; mem_valid = 1'b1; mem_id = 2'd0; mem_rdata = 32'hCAFE_0000;
    kill[1] = 1'b1; result_ready = 1'b1;
    #1;
    chk("t6 no clear in reset", clear, 4'b0000);
    chk("t6 no kill in reset", kill_out, 1'b0);
    tick();
    rst = 1'b0; mem_valid = 1'b0; kill = '0;
    #1;
    chk("t6 ex_ready", ex_ready, 1'b1);
    chk("t6 result_valid", result_valid, 1'b0);
    chk("t6 clear", clear, 4'b0000);
    chk("t6 rf_write", rf_write, 1'b0);
    chk("t6 result_data", result_data, 32'd0);
    chk("t6 result_id", result_id, 2'd0);
    chk("t6 fwd_we", fwd_we, 1'b0);
    sb.delete();
    result_ready = 1'b0; issue = '0; commit = '0;

    // Invalid instructions are accepted and dropped.
    push(2'd2, INSTR_INVALID, 5'd1, 5'd1, 32'd0, 32'd0, 1'b1);
    issue[2] = 1'b1; commit[2] = 1'b1;
    #1;
    chk("invalid dropped", result_valid, 1'b0);
    chk("queue drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fir_xifu_wb_buf.md
Name: fir_xifu_wb_buf

Overview:
Parametrised write-back stage for the FIR XIFU coprocessor that succeeds the single-slot WB stage. It holds up to DEPTH in-flight instructions from EX in an in-order queue and captures out-of-order X-interface memory results by instruction ID. Each instruction retires at the queue head once it is committed and its data is present; retirement is a valid/ready handshake on the core result channel. Retirement writes the XIFU regfile, returns the post-incremented base address to the CV32E40X register file and clears the scoreboard.

Parameters:
XLEN, 32, data and address width
NUM_ID, 4, number of X-interface instruction IDs; ID_W = $clog2(NUM_ID)
DEPTH, 2, queue entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
ex_valid_i  in  1  EX presents an instruction
ex_ready_o  out  1  queue accepts the instruction
ex_id_i  in  ID_W  instruction ID
ex_instr_i  in  instr_t  INSTR_INVALID/XFIRLW/XFIRSW/XFIRDOTP
ex_rd_i  in  5  XIFU destination register
ex_rs1_i  in  5  core base-address register
ex_addr_next_i  in  XLEN  post-incremented base address
ex_result_i  in  XLEN  dot-product result
mem_result_valid_i  in  1  memory result strobe
mem_result_id_i  in  ID_W  memory result ID
mem_result_rdata_i  in  XLEN  load data
issue_i / commit_i / kill_i  in  NUM_ID  scoreboard state per ID
clear_o  out  NUM_ID  one-cycle scoreboard clear per ID
rf_write_o, rf_rd_o[5], rf_result_o[XLEN]  out  XIFU regfile write
result_valid_o  out  1  core result valid
result_ready_i  in  1  core result ready
result_id_o[ID_W], result_rd_o[5], result_data_o[XLEN], result_we_o  out  core result fields
fwd_we_o, fwd_rd_o[5], fwd_result_o[XLEN]  out  forward to EX; mirrors result_we/rd/data, gated by result_valid_o
kill_o  out  1  pipeline flush

Behaviour:
- Reset: queue empty and all per-entry valid and mem-done bits cleared. Every output is 0 except ex_ready_o, which is 1.
- Push: occurs when ex_valid_i & ex_ready_o & ex_instr_i != INSTR_INVALID. An INSTR_INVALID instruction is accepted and dropped.
- ex_ready_o = ~full | retire.
- Push and retire in the same cycle are legal when the queue is full. Pointers wrap modulo DEPTH.
- Memory result capture:
  - A strobe writes rdata into the valid entry whose id matches and sets its mem_done bit.
  - If the matching entry is being pushed in the same cycle, capture still occurs.
  - A strobe with no matching entry is ignored.
- Head ready:
  - XFIRLW/XFIRSW: commit_i[id] & mem_done.
  - XFIRDOTP: commit_i[id].
  - result_valid_o = head valid & head ready & ~kill.
- Retire occurs when result_valid_o & result_ready_i. The retire cycle is combinational from the head entry, and the entry pops on the next edge.
- Retire outputs by instruction:
  - XFIRLW: rf_write_o=1, rf_rd_o=rd, rf_result_o=rdata; result_we_o=1, result_rd_o=rs1, result_data_o=addr_next.
  - XFIRSW: rf_write_o=0; result_we_o=1, result_rd_o=rs1, result_data_o=addr_next.
  - XFIRDOTP: rf_write_o=1, rf_result_o=ex_result; result_we_o=0.
  - All retires: clear_o[id]=1.
- Rules while waiting:
  - rf_write_o and clear_o are only asserted on a retire cycle.
  - result_* fields hold stable while result_valid_o=1 and result_ready_i=0.
- Kill:
  - Triggered when kill_i[id] is set for any valid entry.
  - kill_o=1 for one cycle and clear_o is set for every valid ID.
  - The whole queue flushes on the next edge; no retire happens that cycle, and a push in that cycle is dropped.
- Reset mid-operation: all entries are discarded with no clears emitted.
- An uncommitted head entry (issue & ~commit) stalls the queue indefinitely without error.

Decomposition:
- fir_xifu_pkg gains:
  - instr_t (if not already present);
  - wb_entry_t {id, instr, rd, rs1, addr_next, result, rdata, mem_done};
  - a wb_buf_ctrl_t struct bundling clear_o and kill_o.
- One sub-module, fir_xifu_wb_queue: a DEPTH-entry circular buffer with head/tail pointers, full/empty flags and ID-associative mem_done/rdata update.
- The top level holds retire/kill decoding and output muxing.

Test Plan:
1. XFIRLW id=1 pushed, commit_i[1] rises at cycle 2, mem rdata=0xDEADBEEF arrives at cycle 4, result_ready_i=1 -> at cycle 4: result_valid_o=1, rf_write_o=1, rf_result_o=0xDEADBEEF, result_rd_o=rs1, result_data_o=addr_next, clear_o=4'b0010.
2. Out-of-order memory results: XFIRLW id=0 then id=2 both committed; mem for id=2 arrives before id=0 -> id=0 retires first with its own rdata, and id=2 retires the following cycle.
3. XFIRDOTP result=0x00001234 committed, result_ready_i held 0 for 3 cycles -> result_valid_o=1 with stable fields and no rf_write_o; the retire happens on the first ready cycle, with result_we_o=0.
4. Queue full (DEPTH=2) and the head retires while ex_valid_i=1 -> ex_ready_o=1, the new entry is accepted and the queue stays full.
5. Two entries queued, then kill_i[head id]=1 -> kill_o=1 for one cycle, clear_o covers both IDs, the queue is empty next cycle and nothing retires.
6. rst_i asserted with 2 valid entries and a mem strobe in the same cycle -> next cycle: queue empty, all outputs 0 except ex_ready_o=1.
